// File: rtl/mem_router.sv
// mem_router: routes one core data-bus request to one of NUM_TGT address-decoded
// targets over a valid/ready request and rvalid response handshake. One
// transaction is outstanding at a time; unmapped addresses get an error response.
//
// Optional feature: define MEM_ROUTER_TIMEOUT_EN to abort a transaction with an
// error response after TIMEOUT cycles without target ready/rvalid. Without it,
// the router waits indefinitely and TIMEOUT is unused.
module mem_router #(
  parameter int                          NUM_TGT   = 2,
  parameter int                          ADDR_W    = 30,
  parameter logic [NUM_TGT*ADDR_W-1:0]   TGT_BASE  = {30'h400, 30'h0},
  parameter logic [NUM_TGT*ADDR_W-1:0]   TGT_LIMIT = {30'h4FF, 30'hFF},
  parameter int                          TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_W-1:0]     i_req_addr,
  input  logic [31:0]           i_req_data,
  input  logic [3:0]            i_req_mask,
  input  logic                  i_req_wren,
  output logic                  o_rsp_valid,
  output logic [31:0]           o_rsp_data,
  output logic                  o_rsp_err,
  output logic [NUM_TGT-1:0]    o_tgt_valid,
  output logic [ADDR_W-1:0]     o_tgt_addr,
  output logic [31:0]           o_tgt_data,
  output logic [3:0]            o_tgt_mask,
  output logic                  o_tgt_wren,
  input  logic [NUM_TGT-1:0]    i_tgt_ready,
  input  logic [NUM_TGT-1:0]    i_tgt_rvalid,
  input  logic [NUM_TGT*32-1:0] i_tgt_rdata
);

  localparam int SEL_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RDWAIT,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         data_q;
  logic [3:0]          mask_q;
  logic                wren_q;
  logic [31:0]         rsp_data_q;
  logic                rsp_err_q;

  logic                dec_hit;
  logic [SEL_W-1:0]    dec_sel;
  logic [ADDR_W-1:0]   dec_offset;

  logic                sel_ready;
  logic                sel_rvalid;
  logic [31:0]         sel_rdata;
  logic [NUM_TGT-1:0]  tgt_valid;

  logic                accept;
  logic                rsp_load;
  logic [31:0]         rsp_data_d;
  logic                rsp_err_d;
  logic                timeout_hit;

  // Address decode: first (lowest-index) window containing the address wins.
  always_comb begin
    // NOTE: every variable gets a default before any condition, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    dec_hit    = 1'b0;
    dec_sel    = '0;
    dec_offset = i_req_addr;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (!dec_hit &&
          i_req_addr >= TGT_BASE[i*ADDR_W +: ADDR_W] &&
          i_req_addr <= TGT_LIMIT[i*ADDR_W +: ADDR_W]) begin
        dec_hit    = 1'b1;
        dec_sel    = SEL_W'(i);
        // A hit guarantees addr >= base, so the subtraction cannot wrap.
        dec_offset = i_req_addr - TGT_BASE[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Select the handshake/data of the latched target; all others are ignored.
  always_comb begin
    sel_ready  = 1'b0;
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    tgt_valid  = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ready    = i_tgt_ready[i];
        sel_rvalid   = i_tgt_rvalid[i];
        sel_rdata    = i_tgt_rdata[i*32 +: 32];
        tgt_valid[i] = (state_q == S_REQ);
      end
    end
  end

`ifdef MEM_ROUTER_TIMEOUT_EN
  localparam int                CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Wait counter: restarts on entering REQ/RDWAIT, counts cycles spent waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_d != state_q && (state_d == S_REQ || state_d == S_RDWAIT)) begin
      cnt_q <= '0;
    end else if (state_q == S_REQ || state_q == S_RDWAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The TIMEOUT-th waiting cycle without progress ends the transaction.
  assign timeout_hit = (cnt_q == TO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
`endif

  assign accept = i_req_valid && (state_q == S_IDLE);

  // Next-state and response-capture decisions.
  always_comb begin
    state_d    = state_q;
    rsp_load   = 1'b0;
    rsp_data_d = '0;
    rsp_err_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          if (dec_hit) begin
            state_d = S_REQ;
          end else begin
            state_d   = S_RESP;
            rsp_load  = 1'b1;
            rsp_err_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (sel_ready) begin
          if (wren_q) begin
            state_d  = S_RESP;
            rsp_load = 1'b1;
          end else if (sel_rvalid) begin
            state_d    = S_RESP;
            rsp_load   = 1'b1;
            rsp_data_d = sel_rdata;
          end else begin
            state_d = S_RDWAIT;
          end
        end else if (timeout_hit) begin
          state_d   = S_RESP;
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      S_RDWAIT: begin
        if (sel_rvalid) begin
          state_d    = S_RESP;
          rsp_load   = 1'b1;
          rsp_data_d = sel_rdata;
        end else if (timeout_hit) begin
          state_d   = S_RESP;
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, request payload and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      wren_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      if (accept) begin
        sel_q  <= dec_sel;
        addr_q <= dec_offset;
        data_q <= i_req_data;
        mask_q <= i_req_mask;
        wren_q <= i_req_wren;
      end
      // Response fields update only when a response is produced, then hold.
      if (rsp_load) begin
        rsp_data_q <= rsp_data_d;
        rsp_err_q  <= rsp_err_d;
      end
    end
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_rsp_valid = (state_q == S_RESP);
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_tgt_valid = tgt_valid;
  assign o_tgt_addr  = addr_q;
  assign o_tgt_data  = data_q;
  assign o_tgt_mask  = mask_q;
  assign o_tgt_wren  = wren_q;

endmodule

// File: tb/tb_mem_router.sv
// tb_mem_router: directed self-checking bench for mem_router (two targets:
// words 0x000-0x0FF and 0x400-0x4FF). Inputs change and outputs are sampled on
// the falling edge; "cycle N" counts rising edges after the request cycle.
module tb_mem_router;

  localparam int NUM_TGT = 2;
  localparam int ADDR_W  = 30;
  localparam int TO_CYC  = 8;

  logic                  clk;
  logic                  rst_n;
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic [ADDR_W-1:0]     i_req_addr;
  logic [31:0]           i_req_data;
  logic [3:0]            i_req_mask;
  logic                  i_req_wren;
  logic                  o_rsp_valid;
  logic [31:0]           o_rsp_data;
  logic                  o_rsp_err;
  logic [NUM_TGT-1:0]    o_tgt_valid;
  logic [ADDR_W-1:0]     o_tgt_addr;
  logic [31:0]           o_tgt_data;
  logic [3:0]            o_tgt_mask;
  logic                  o_tgt_wren;
  logic [NUM_TGT-1:0]    i_tgt_ready;
  logic [NUM_TGT-1:0]    i_tgt_rvalid;
  logic [NUM_TGT*32-1:0] i_tgt_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_router #(
    .NUM_TGT (NUM_TGT),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TO_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_addr   (i_req_addr),
    .i_req_data   (i_req_data),
    .i_req_mask   (i_req_mask),
    .i_req_wren   (i_req_wren),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_err    (o_rsp_err),
    .o_tgt_valid  (o_tgt_valid),
    .o_tgt_addr   (o_tgt_addr),
    .o_tgt_data   (o_tgt_data),
    .o_tgt_mask   (o_tgt_mask),
    .o_tgt_wren   (o_tgt_wren),
    .i_tgt_ready  (i_tgt_ready),
    .i_tgt_rvalid (i_tgt_rvalid),
    .i_tgt_rdata  (i_tgt_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic drive_req(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                           input logic [3:0] mask, input logic wren);
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    i_req_data  = data;
    i_req_mask  = mask;
    i_req_wren  = wren;
  endtask

  task automatic test_reset;
    rst_n        = 1'b0;
    i_req_valid  = 1'b0;
    i_req_addr   = '0;
    i_req_data   = '0;
    i_req_mask   = '0;
    i_req_wren   = 1'b0;
    i_tgt_ready  = '0;
    i_tgt_rvalid = '0;
    i_tgt_rdata  = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_tgt_valid !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_ctrl: ready/rsp_valid/tgt_valid got %b/%b/%b want 1/0/00",
               o_req_ready, o_rsp_valid, o_tgt_valid);
    end
    tests_run++;
    if (o_rsp_data !== 32'h0 || o_rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rsp: data/err got %h/%b want 00000000/0", o_rsp_data, o_rsp_err);
    end
    tests_run++;
    if (o_tgt_addr !== '0 || o_tgt_data !== 32'h0 || o_tgt_mask !== 4'h0 || o_tgt_wren !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_payload: addr/data/mask/wren got %h/%h/%h/%b want 0/0/0/0",
               o_tgt_addr, o_tgt_data, o_tgt_mask, o_tgt_wren);
    end
    rst_n = 1'b1;
  endtask

  // Read word 0x10 from target 0, ready and rvalid together in cycle 1.
  task automatic test_read_t0;
    @(negedge clk);
    drive_req(30'h10, 32'h0, 4'hF, 1'b0);
    @(negedge clk);                       // cycle 1
    i_req_valid = 1'b0;
    tests_run++;
    if (o_tgt_valid !== 2'b01 || o_tgt_addr !== 30'h10 || o_tgt_wren !== 1'b0 || o_rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd0_request: tgt_valid/addr/wren/rsp_valid got %b/%h/%b/%b want 01/10/0/0",
               o_tgt_valid, o_tgt_addr, o_tgt_wren, o_rsp_valid);
    end
    i_tgt_ready  = 2'b01;
    i_tgt_rvalid = 2'b01;
    i_tgt_rdata  = {32'h5555_AAAA, 32'hDEAD_BEEF};
    @(negedge clk);                       // cycle 2
    i_tgt_ready  = 2'b00;
    i_tgt_rvalid = 2'b00;
    i_tgt_rdata  = {32'h0, 32'h0BAD_0BAD};
    tests_run++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'hDEAD_BEEF || o_rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd0_response: valid/data/err got %b/%h/%b want 1/deadbeef/0",
               o_rsp_valid, o_rsp_data, o_rsp_err);
    end
    tests_run++;
    if (o_tgt_valid !== 2'b00 || o_req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd0_resp_state: tgt_valid/req_ready got %b/%b want 00/0", o_tgt_valid, o_req_ready);
    end
    @(negedge clk);                       // cycle 3
    tests_run++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_rsp_data !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL rd0_after: rsp_valid/req_ready/data got %b/%b/%h want 0/1/deadbeef",
               o_rsp_valid, o_req_ready, o_rsp_data);
    end
  endtask

  // Read of unmapped word 0x300: error response in cycle 1, no target request.
  task automatic test_unmapped;
    drive_req(30'h300, 32'h0, 4'hF, 1'b0);
    @(negedge clk);                       // cycle 1
    i_req_valid = 1'b0;
    tests_run++;
    if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b1 || o_rsp_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL unmapped_rsp: valid/err/data got %b/%b/%h want 1/1/00000000",
               o_rsp_valid, o_rsp_err, o_rsp_data);
    end
    tests_run++;
    if (o_tgt_valid !== 2'b00) begin
      tests_failed++;
      $display("FAIL unmapped_tgt_c1: tgt_valid got %b want 00", o_tgt_valid);
    end
    @(negedge clk);                       // cycle 2
    tests_run++;
    if (o_rsp_valid !== 1'b0 || o_rsp_err !== 1'b1 || o_tgt_valid !== 2'b00 || o_req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL unmapped_after: rsp_valid/err/tgt_valid/ready got %b/%b/%b/%b want 0/1/00/1",
               o_rsp_valid, o_rsp_err, o_tgt_valid, o_req_ready);
    end
  endtask

  // Write word 0x402 to target 1, which stalls for cycles 1-3 and is ready in cycle 4.
  // Target 0 raises ready during the stall and must be ignored.
  task automatic test_write_stall;
    drive_req(30'h402, 32'h1234_5678, 4'b0011, 1'b1);
    @(negedge clk);                       // cycle 1
    i_req_valid = 1'b0;
    i_req_data  = 32'hFFFF_FFFF;
    i_req_mask  = 4'hF;
    i_tgt_ready = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      tests_run++;
      if (o_tgt_valid !== 2'b10 || o_tgt_addr !== 30'h2 || o_tgt_data !== 32'h1234_5678 ||
          o_tgt_mask !== 4'b0011 || o_tgt_wren !== 1'b1 || o_rsp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL wr_stall_c%0d: valid/addr/data/mask/wren/rsp got %b/%h/%h/%b/%b/%b want 10/2/12345678/0011/1/0",
                 c, o_tgt_valid, o_tgt_addr, o_tgt_data, o_tgt_mask, o_tgt_wren, o_rsp_valid);
      end
      if (c == 4) i_tgt_ready = 2'b10;
      @(negedge clk);
    end
    // cycle 5
    i_tgt_ready = 2'b00;
    tests_run++;
    if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b0 || o_rsp_data !== 32'h0 || o_tgt_valid !== 2'b00) begin
      tests_failed++;
      $display("FAIL wr_response: valid/err/data/tgt_valid got %b/%b/%h/%b want 1/0/00000000/00",
               o_rsp_valid, o_rsp_err, o_rsp_data, o_tgt_valid);
    end
    @(negedge clk);
  endtask

  // Read word 0x401: ready in cycle 1 without data, target 0 rvalid in cycle 3
  // (ignored), target 1 rvalid in cycle 5, response in cycle 6.
  task automatic test_late_rvalid;
    drive_req(30'h401, 32'h0, 4'hF, 1'b0);
    @(negedge clk);                       // cycle 1
    i_req_valid = 1'b0;
    tests_run++;
    if (o_tgt_valid !== 2'b10 || o_tgt_addr !== 30'h1) begin
      tests_failed++;
      $display("FAIL late_request: tgt_valid/addr got %b/%h want 10/1", o_tgt_valid, o_tgt_addr);
    end
    i_tgt_ready = 2'b10;
    @(negedge clk);                       // cycle 2
    i_tgt_ready = 2'b00;
    tests_run++;
    if (o_tgt_valid !== 2'b00 || o_rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_rdwait: tgt_valid/rsp_valid got %b/%b want 00/0", o_tgt_valid, o_rsp_valid);
    end
    @(negedge clk);                       // cycle 3
    i_tgt_rvalid = 2'b01;
    i_tgt_rdata  = {32'h0, 32'hBAD0_BAD0};
    for (int c = 4; c <= 5; c++) begin
      @(negedge clk);
      i_tgt_rvalid = (c == 5) ? 2'b10 : 2'b00;
      i_tgt_rdata  = (c == 5) ? {32'hCAFE_F00D, 32'h1111_2222} : '0;
      tests_run++;
      if (o_rsp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL late_no_rsp_c%0d: rsp_valid got %b want 0", c, o_rsp_valid);
      end
    end
    @(negedge clk);                       // cycle 6
    i_tgt_rvalid = 2'b00;
    i_tgt_rdata  = '0;
    tests_run++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'hCAFE_F00D || o_rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_response: valid/data/err got %b/%h/%b want 1/cafef00d/0",
               o_rsp_valid, o_rsp_data, o_rsp_err);
    end
    @(negedge clk);
  endtask

  // Two reads with req_valid held high, then reset while the second sits in RDWAIT.
  task automatic test_back_to_back;
    drive_req(30'h20, 32'h0, 4'hF, 1'b0);
    @(negedge clk);                       // cycle 1: first request at target
    i_req_addr = 30'h21;
    tests_run++;
    if (o_tgt_valid !== 2'b01 || o_tgt_addr !== 30'h20 || o_req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_first: tgt_valid/addr/ready got %b/%h/%b want 01/20/0",
               o_tgt_valid, o_tgt_addr, o_req_ready);
    end
    i_tgt_ready  = 2'b01;
    i_tgt_rvalid = 2'b01;
    i_tgt_rdata  = {32'h0, 32'h1111_1111};
    @(negedge clk);                       // cycle 2: first response
    i_tgt_ready  = 2'b00;
    i_tgt_rvalid = 2'b00;
    tests_run++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'h1111_1111 || o_req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_rsp1: valid/data/ready got %b/%h/%b want 1/11111111/0",
               o_rsp_valid, o_rsp_data, o_req_ready);
    end
    @(negedge clk);                       // cycle 3: second request accepted here
    tests_run++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_tgt_valid !== 2'b00) begin
      tests_failed++;
      $display("FAIL b2b_idle: ready/rsp_valid/tgt_valid got %b/%b/%b want 1/0/00",
               o_req_ready, o_rsp_valid, o_tgt_valid);
    end
    @(negedge clk);                       // cycle 4
    i_req_valid = 1'b0;
    tests_run++;
    if (o_tgt_valid !== 2'b01 || o_tgt_addr !== 30'h21) begin
      tests_failed++;
      $display("FAIL b2b_second: tgt_valid/addr got %b/%h want 01/21", o_tgt_valid, o_tgt_addr);
    end
    i_tgt_ready = 2'b01;
    @(negedge clk);                       // cycle 5: RDWAIT
    i_tgt_ready = 2'b00;
    tests_run++;
    if (o_tgt_valid !== 2'b00 || o_req_ready !== 1'b0 || o_rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_rdwait: tgt_valid/ready/rsp_valid got %b/%b/%b want 00/0/0",
               o_tgt_valid, o_req_ready, o_rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_rsp_data !== 32'h0 ||
        o_rsp_err !== 1'b0 || o_tgt_addr !== '0 || o_tgt_wren !== 1'b0 || o_tgt_mask !== 4'h0) begin
      tests_failed++;
      $display("FAIL b2b_reset: ready/rsp_valid/data/err/addr/wren/mask got %b/%b/%h/%b/%h/%b/%h want 1/0/0/0/0/0/0",
               o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_tgt_addr, o_tgt_wren, o_tgt_mask);
    end
    @(negedge clk);
    rst_n        = 1'b1;
    i_tgt_rvalid = 2'b01;
    i_tgt_rdata  = {32'h0, 32'h7777_7777};
    @(negedge clk);                       // late rvalid seen in IDLE
    i_tgt_rvalid = 2'b00;
    @(negedge clk);
    tests_run++;
    if (o_rsp_valid !== 1'b0 || o_rsp_data !== 32'h0 || o_req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_late_rvalid: rsp_valid/data/ready got %b/%h/%b want 0/00000000/1",
               o_rsp_valid, o_rsp_data, o_req_ready);
    end
  endtask

  // Write to target 1 that never becomes ready.
  task automatic test_stuck_target;
    drive_req(30'h405, 32'hA5A5_A5A5, 4'hF, 1'b1);
    @(negedge clk);                       // cycle 1
    i_req_valid = 1'b0;
`ifdef MEM_ROUTER_TIMEOUT_EN
    for (int c = 1; c <= TO_CYC; c++) begin
      tests_run++;
      if (o_tgt_valid !== 2'b10 || o_rsp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL to_wait_c%0d: tgt_valid/rsp_valid got %b/%b want 10/0", c, o_tgt_valid, o_rsp_valid);
      end
      @(negedge clk);
    end
    tests_run++;
    if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b1 || o_rsp_data !== 32'h0 || o_tgt_valid !== 2'b00) begin
      tests_failed++;
      $display("FAIL to_response: valid/err/data/tgt_valid got %b/%b/%h/%b want 1/1/00000000/00",
               o_rsp_valid, o_rsp_err, o_rsp_data, o_tgt_valid);
    end
`else
    for (int c = 1; c <= TO_CYC + 4; c++) begin
      tests_run++;
      if (o_tgt_valid !== 2'b10 || o_rsp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL wait_c%0d: tgt_valid/rsp_valid got %b/%b want 10/0", c, o_tgt_valid, o_rsp_valid);
      end
      if (c == TO_CYC + 4) i_tgt_ready = 2'b10;
      @(negedge clk);
    end
    i_tgt_ready = 2'b00;
    tests_run++;
    if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b0 || o_tgt_valid !== 2'b00) begin
      tests_failed++;
      $display("FAIL wait_response: valid/err/tgt_valid got %b/%b/%b want 1/0/00",
               o_rsp_valid, o_rsp_err, o_tgt_valid);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_t0();
    test_unmapped();
    test_write_stall();
    test_late_rvalid();
    test_back_to_back();
    test_stuck_target();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
